sklansky_subtractor_pipe: RTL and testbench

- Pipelined two's-complement subtractor built on a Sklansky parallel-prefix borrow tree.
- Computes D = A - B - Bin with borrow-out, signed-overflow and zero flags.
- Counterpart to the combinational Sklansky adder; used where datapaths need subtraction at full clock rate with back-pressure.
- Valid/ready on both sides, two register stages, throughput of one operation per cycle.

---
 rtl/sklansky_subtractor_pipe.sv | 79 +++++++
 tb/tb_sklansky_subtractor_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sklansky_subtractor_pipe.sv
// sklansky_subtractor_pipe: two-stage valid/ready subtractor D = A - B - Bin on a radix-2 Sklansky borrow tree
module sklansky_subtractor_pipe #(
  parameter int WIDTH = 16,
  parameter int VALENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero
);
  localparam int LEVELS = $clog2(WIDTH);
  if (VALENCY != 2 || WIDTH < 2) begin : g_bad_param
    $error("sklansky_subtractor_pipe: VALENCY must be 2 and WIDTH must be >= 2");
  end
  logic             s1_valid, s2_valid, s2_load;
  logic [WIDTH-1:0] s1_g, s1_p, gg, pp, d;
  logic             s1_cin, s1_am, s1_bm;
  assign s2_load   = ~s2_valid | out_ready;
  assign in_ready  = ~rst & (~s1_valid | s2_load);
  assign out_valid = ~rst & s2_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_cin   <= 1'b0;
      s1_am    <= 1'b0;
      s1_bm    <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_g     <= A & ~B;
      s1_p     <= A ^ ~B;
      s1_cin   <= ~Bin;
      s1_am    <= A[WIDTH-1];
      s1_bm    <= B[WIDTH-1];
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end
  // carry-in folded into bit 0 so the tree only spans WIDTH positions
  always_comb begin
    gg    = s1_g;
    pp    = s1_p;
    gg[0] = s1_g[0] | (s1_p[0] & s1_cin);
    for (int l = 0; l < LEVELS; l++)
      for (int i = 0; i < WIDTH; i++)
        if (((i >> l) & 1) == 1) begin
          gg[i] = gg[i] | (pp[i] & gg[((i >> l) << l) - 1]);
          pp[i] = pp[i] & pp[((i >> l) << l) - 1];
        end
    d = s1_p ^ {gg[WIDTH-2:0], s1_cin};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      D        <= '0;
      Bout     <= 1'b0;
      Ovf      <= 1'b0;
      Zero     <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        D    <= d;
        Bout <= ~gg[WIDTH-1];
        Ovf  <= (s1_am != s1_bm) & (d[WIDTH-1] != s1_am);
        Zero <= ~|d;
      end
    end
  end
endmodule

// File: tb/tb_sklansky_subtractor_pipe.sv
// tb_sklansky_subtractor_pipe: directed and randomized checks of the pipelined subtractor at widths 16, 8 and 13
module tb_sklansky_subtractor_pipe;
  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, bin;
  logic [15:0] a, b;
  logic [2:0]  ir, ovl, bo, ovf, zr;
  logic [15:0] d16;
  logic [7:0]  d8;
  logic [12:0] d13;
  int          assertions = 0;
  int          failures = 0;
  int          ws[3] = '{16, 8, 13};
  exp_t        q[3][$];
  always #5 clk = ~clk;
  sklansky_subtractor_pipe #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .A(a), .B(b), .Bin(bin), .out_valid(ovl[0]), .out_ready(out_ready), .D(d16), .Bout(bo[0]), .Ovf(ovf[0]), .Zero(zr[0]));
  sklansky_subtractor_pipe #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .A(a[7:0]), .B(b[7:0]), .Bin(bin), .out_valid(ovl[1]), .out_ready(out_ready), .D(d8), .Bout(bo[1]), .Ovf(ovf[1]), .Zero(zr[1]));
  sklansky_subtractor_pipe #(.WIDTH(13)) u13 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .A(a[12:0]), .B(b[12:0]), .Bin(bin), .out_valid(ovl[2]), .out_ready(out_ready), .D(d13), .Bout(bo[2]), .Ovf(ovf[2]), .Zero(zr[2]));
  // reference: plain integer subtraction on the low w bits
  function automatic exp_t model(int w, logic [15:0] x, logic [15:0] y, logic c);
    longint m = (longint'(1) << w) - 1;
    longint diff = (longint'(x) & m) - (longint'(y) & m) - longint'(c);
    exp_t e;
    e.d  = 16'(diff & m);
    e.bo = diff < 0;
    e.ov = (x[w-1] != y[w-1]) && (e.d[w-1] != x[w-1]);
    e.z  = e.d == 16'h0;
    return e;
  endfunction
  function automatic exp_t act(int k);
    exp_t e;
    e.d  = k == 0 ? d16 : k == 1 ? {8'h0, d8} : {3'h0, d13};
    e.bo = bo[k];
    e.ov = ovf[k];
    e.z  = zr[k];
    return e;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic v, logic [15:0] x, logic [15:0] y, logic c);
    in_valid = v;
    a = x;
    b = y;
    bin = c;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    do_reset();
    assertions++;
    if ({ovl[0], ir[0], d16, bo[0], ovf[0], zr[0]} !== {1'b0, 1'b1, 16'h0, 3'b000}) begin
      failures++;
      $display("FAIL reset_state: got ov=%b ir=%b D=%h flags=%b%b%b required ov=0 ir=1 D=0000 flags=000",
               ovl[0], ir[0], d16, bo[0], ovf[0], zr[0]);
    end
  endtask
  task automatic run_op(string name, logic [15:0] x, logic [15:0] y, logic c, exp_t e);
    out_ready = 1'b1;
    drive(1'b1, x, y, c);
    #1;
    assertions++;
    if (ir[0] !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready: got in_ready=%b required 1", name, ir[0]);
    end
    step();
    in_valid = 1'b0;
    assertions++;
    if (ovl[0] !== 1'b0) begin
      failures++;
      $display("FAIL %s_early: got out_valid=%b required 0 after one edge", name, ovl[0]);
    end
    step();
    assertions++;
    if (ovl[0] !== 1'b1 || act(0) !== e) begin
      failures++;
      $display("FAIL %s: got v=%b D=%h bo=%b ov=%b z=%b required v=1 D=%h bo=%b ov=%b z=%b",
               name, ovl[0], d16, bo[0], ovf[0], zr[0], e.d, e.bo, e.ov, e.z);
    end
    step();
  endtask
  task automatic test_directed();
    run_op("sub_5_3", 16'h0005, 16'h0003, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0});
    run_op("sub_0_1", 16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0});
    run_op("sub_eq", 16'h1234, 16'h1234, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b1});
    run_op("sub_eq_bin", 16'h1234, 16'h1234, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0});
    run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0});
    run_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, '{16'h8000, 1'b1, 1'b1, 1'b0});
  endtask
  task automatic test_back_pressure();
    logic [15:0] oa[6], ob[6];
    logic        oc[6];
    logic [15:0] held = 16'h0;
    logic        have = 1'b0;
    int          n = 0, got = 0, first = -1, last = -1;
    for (int i = 0; i < 6; i++) begin
      oa[i] = 16'($urandom);
      ob[i] = 16'($urandom);
      oc[i] = 1'($urandom);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, oa[n], ob[n], oc[n]);
      #1;
      if (ovl[0]) begin
        if (have) begin
          assertions++;
          if (d16 !== held) begin
            failures++;
            $display("FAIL stall_hold: got D=%h required %h", d16, held);
          end
        end
        held = d16;
        have = 1'b1;
      end
      if (ir[0]) n++;
      step();
    end
    drive(1'b1, oa[n], ob[n], oc[n]);
    #1;
    assertions++;
    if (n != 2 || ir[0] !== 1'b0 || ovl[0] !== 1'b1 || d16 !== held) begin
      failures++;
      $display("FAIL stall_fill: got accepted=%0d in_ready=%b out_valid=%b D=%h required 2 0 1 %h",
               n, ir[0], ovl[0], d16, held);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 6; c++) begin
      if (n < 6) drive(1'b1, oa[n], ob[n], oc[n]);
      else in_valid = 1'b0;
      #1;
      if (ovl[0]) begin
        exp_t e = model(16, oa[got], ob[got], oc[got]);
        assertions++;
        if (act(0) !== e) begin
          failures++;
          $display("FAIL drain_%0d: got D=%h flags=%b%b%b required D=%h flags=%b%b%b",
                   got, d16, bo[0], ovf[0], zr[0], e.d, e.bo, e.ov, e.z);
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (in_valid && ir[0]) n++;
      step();
    end
    in_valid = 1'b0;
    assertions++;
    if (got != 6 || last - first != 5) begin
      failures++;
      $display("FAIL drain_count: got %0d results over %0d cycles required 6 over 6", got, last - first + 1);
    end
  endtask
  task automatic test_mid_reset();
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 16'h0001, 1'b0);
    step();
    drive(1'b1, 16'h2222, 16'h0002, 1'b0);
    step();
    in_valid = 1'b0;
    assertions++;
    if (ovl[0] !== 1'b1 || ir[0] !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_full: got out_valid=%b in_ready=%b required 1 0", ovl[0], ir[0]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    assertions++;
    if (ovl[0] !== 1'b0 || ir[0] !== 1'b1 || d16 !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset: got out_valid=%b in_ready=%b D=%h required 0 1 0000", ovl[0], ir[0], d16);
    end
    run_op("after_reset", 16'h0100, 16'h0001, 1'b1, '{16'h00FE, 1'b0, 1'b0, 1'b0});
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 13000; c++) begin
      drive(1'($urandom_range(3) != 0), 16'($urandom), 16'($urandom), 1'($urandom));
      out_ready = 1'($urandom_range(3) != 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (q[k].size() < 2) begin
          assertions++;
          if (ir[k] !== 1'b1) begin
            failures++;
            $display("FAIL rand_w%0d_ready: got in_ready=%b with %0d in flight required 1", ws[k], ir[k], q[k].size());
          end
        end
        if (ovl[k] && out_ready) begin
          assertions++;
          if (q[k].size() == 0) begin
            failures++;
            $display("FAIL rand_w%0d_spurious: got out_valid=1 required no pending result", ws[k]);
          end else begin
            exp_t e = q[k].pop_front();
            if (act(k) !== e) begin
              failures++;
              $display("FAIL rand_w%0d: got D=%h flags=%b%b%b required D=%h flags=%b%b%b",
                       ws[k], act(k).d, bo[k], ovf[k], zr[k], e.d, e.bo, e.ov, e.z);
            end
          end
        end
        if (in_valid && ir[k]) q[k].push_back(model(ws[k], a, b, bin));
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      for (int k = 0; k < 3; k++)
        if (ovl[k] && q[k].size() > 0) begin
          exp_t e = q[k].pop_front();
          assertions++;
          if (act(k) !== e) begin
            failures++;
            $display("FAIL flush_w%0d: got D=%h required D=%h", ws[k], act(k).d, e.d);
          end
        end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      assertions++;
      if (q[k].size() != 0) begin
        failures++;
        $display("FAIL rand_w%0d_lost: got %0d results outstanding required 0", ws[k], q[k].size());
      end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
